// File: rtl/dbus_uart_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbus_uart_xfer_ctrl (+ dbus_uart_xfer_dir)
// Brief    : Two-direction UART FIFO <-> dbus transfer engine with skid FIFOs,
//            four-phase source/sink handshakes and sticky ack-timeout flags.
// Revision : 1.0 - initial release
// ============================================================================

module dbus_uart_xfer_dir #(
    parameter int c_WIDTH     = 8,
    parameter int c_ADDRWIDTH = 2,
    parameter int c_SYNC      = 1,
    parameter int c_TIMEOUT   = 255
) (
    input  logic                   i_clock,
    input  logic                   i_rst_n,
    input  logic                   i_src_avail,
    input  logic [c_WIDTH-1:0]     i_src_data,
    output logic                   o_src_read,
    output logic [c_WIDTH-1:0]     o_snk_data,
    output logic                   o_snk_enable,
    input  logic                   i_snk_busy,
    output logic [c_ADDRWIDTH:0]   o_level,
    output logic                   o_err,
    input  logic                   i_err_clear
);
    localparam int c_DEPTH = 2 ** c_ADDRWIDTH;
    localparam int c_LW    = c_ADDRWIDTH + 1;
    localparam int c_TW    = (c_TIMEOUT > 1) ? $clog2(c_TIMEOUT) : 1;
    localparam int c_TLIM  = (c_TIMEOUT == 0) ? 0 : c_TIMEOUT - 1;
    localparam logic [c_TW-1:0] c_TLIM_V = c_TW'(c_TLIM);
    localparam logic [c_LW-1:0] c_FULL   = c_LW'(c_DEPTH);

    typedef enum logic [0:0] {S_IDLE, S_WAITLOW} src_state_t;
    typedef enum logic [1:0] {K_IDLE, K_WAITACK, K_WAITIDLE} snk_state_t;

    src_state_t               r_src_state;
    snk_state_t               r_snk_state;
    logic [c_SYNC-1:0]        r_avail_sync;
    logic [c_SYNC-1:0]        r_busy_sync;
    logic [c_WIDTH-1:0]       r_mem [c_DEPTH];
    logic [c_ADDRWIDTH-1:0]   r_wr_ptr;
    logic [c_ADDRWIDTH-1:0]   r_rd_ptr;
    logic [c_LW-1:0]          r_level;
    logic [c_TW-1:0]          r_timer;
    logic                     w_avail_s;
    logic                     w_busy_s;
    logic                     w_push;
    logic                     w_pop;

    // busy resets high so the sink never fires before it has seen an idle sink
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_avail_sync <= '0;
            r_busy_sync  <= '1;
        end else begin
            r_avail_sync[0] <= i_src_avail;
            r_busy_sync[0]  <= i_snk_busy;
            for (int k = 1; k < c_SYNC; k++) begin
                r_avail_sync[k] <= r_avail_sync[k-1];
                r_busy_sync[k]  <= r_busy_sync[k-1];
            end
        end
    end

    assign w_avail_s = r_avail_sync[c_SYNC-1];
    assign w_busy_s  = r_busy_sync[c_SYNC-1];
    assign w_push    = (r_src_state == S_IDLE) && w_avail_s && (r_level != c_FULL);
    assign w_pop     = (r_snk_state == K_IDLE) && (r_level != '0) && !w_busy_s;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src_state <= S_IDLE;
            o_src_read  <= 1'b0;
        end else begin
            case (r_src_state)
                S_IDLE: begin
                    if (w_push) begin
                        o_src_read  <= 1'b1;
                        r_src_state <= S_WAITLOW;
                    end
                end
                S_WAITLOW: begin
                    if (!w_avail_s) begin
                        o_src_read  <= 1'b0;
                        r_src_state <= S_IDLE;
                    end
                end
                default: r_src_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_src_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDRWIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDRWIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A timeout set on the same edge as a clear overrides it (later assignment)
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_snk_state  <= K_IDLE;
            o_snk_enable <= 1'b0;
            o_snk_data   <= '0;
            r_timer      <= '0;
            o_err        <= 1'b0;
        end else begin
            if (i_err_clear) o_err <= 1'b0;
            case (r_snk_state)
                K_IDLE: begin
                    if (w_pop) begin
                        o_snk_data   <= r_mem[r_rd_ptr];
                        o_snk_enable <= 1'b1;
                        r_timer      <= '0;
                        r_snk_state  <= K_WAITACK;
                    end
                end
                K_WAITACK: begin
                    if (w_busy_s) begin
                        o_snk_enable <= 1'b0;
                        r_snk_state  <= K_WAITIDLE;
                    end else if ((c_TIMEOUT != 0) && (r_timer == c_TLIM_V)) begin
                        o_snk_enable <= 1'b0;
                        o_err        <= 1'b1;
                        r_snk_state  <= K_WAITIDLE;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                K_WAITIDLE: begin
                    if (!w_busy_s) r_snk_state <= K_IDLE;
                end
                default: r_snk_state <= K_IDLE;
            endcase
        end
    end

    assign o_level = r_level;
endmodule

module dbus_uart_xfer_ctrl #(
    parameter int c_WIDTH     = 8,
    parameter int c_ADDRWIDTH = 2,
    parameter int c_SYNC      = 1,
    parameter int c_TIMEOUT   = 255
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_u2d_src_avail,
    input  logic [c_WIDTH-1:0]     i_u2d_src_data,
    output logic                   o_u2d_src_read,
    output logic [c_WIDTH-1:0]     o_u2d_snk_data,
    output logic                   o_u2d_snk_enable,
    input  logic                   i_u2d_snk_busy,
    output logic [c_ADDRWIDTH:0]   o_u2d_level,
    input  logic                   i_d2u_src_avail,
    input  logic [c_WIDTH-1:0]     i_d2u_src_data,
    output logic                   o_d2u_src_read,
    output logic [c_WIDTH-1:0]     o_d2u_snk_data,
    output logic                   o_d2u_snk_enable,
    input  logic                   i_d2u_snk_busy,
    output logic [c_ADDRWIDTH:0]   o_d2u_level,
    output logic [1:0]             o_err,
    input  logic                   i_err_clear
);
    logic r_rst_meta;
    logic r_rst_n;
    logic w_err_u2d;
    logic w_err_d2u;

    // Asynchronous assertion, release re-timed to i_clock
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    dbus_uart_xfer_dir #(
        .c_WIDTH(c_WIDTH), .c_ADDRWIDTH(c_ADDRWIDTH),
        .c_SYNC(c_SYNC), .c_TIMEOUT(c_TIMEOUT)
    ) u_u2d (
        .i_clock      (i_clock),
        .i_rst_n      (r_rst_n),
        .i_src_avail  (i_u2d_src_avail),
        .i_src_data   (i_u2d_src_data),
        .o_src_read   (o_u2d_src_read),
        .o_snk_data   (o_u2d_snk_data),
        .o_snk_enable (o_u2d_snk_enable),
        .i_snk_busy   (i_u2d_snk_busy),
        .o_level      (o_u2d_level),
        .o_err        (w_err_u2d),
        .i_err_clear  (i_err_clear)
    );

    dbus_uart_xfer_dir #(
        .c_WIDTH(c_WIDTH), .c_ADDRWIDTH(c_ADDRWIDTH),
        .c_SYNC(c_SYNC), .c_TIMEOUT(c_TIMEOUT)
    ) u_d2u (
        .i_clock      (i_clock),
        .i_rst_n      (r_rst_n),
        .i_src_avail  (i_d2u_src_avail),
        .i_src_data   (i_d2u_src_data),
        .o_src_read   (o_d2u_src_read),
        .o_snk_data   (o_d2u_snk_data),
        .o_snk_enable (o_d2u_snk_enable),
        .i_snk_busy   (i_d2u_snk_busy),
        .o_level      (o_d2u_level),
        .o_err        (w_err_d2u),
        .i_err_clear  (i_err_clear)
    );

    assign o_err = {w_err_d2u, w_err_u2d};
endmodule
`default_nettype wire

// File: tb/tb_dbus_uart_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_uart_xfer_ctrl
// Brief    : Directed self-checking bench; index 0 = u2d, index 1 = d2u.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dbus_uart_xfer_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] src_avail;
    logic [1:0] snk_busy;
    logic [7:0] src_data [2];
    logic       err_clear;
    wire  [1:0] src_read;
    wire  [1:0] snk_enable;
    wire  [7:0] snk_data [2];
    wire  [2:0] level [2];
    wire  [1:0] err;

    int n_cmp = 0;
    int n_err = 0;

    dbus_uart_xfer_ctrl #(
        .c_WIDTH(8), .c_ADDRWIDTH(2), .c_SYNC(1), .c_TIMEOUT(8)
    ) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_u2d_src_avail  (src_avail[0]),
        .i_u2d_src_data   (src_data[0]),
        .o_u2d_src_read   (src_read[0]),
        .o_u2d_snk_data   (snk_data[0]),
        .o_u2d_snk_enable (snk_enable[0]),
        .i_u2d_snk_busy   (snk_busy[0]),
        .o_u2d_level      (level[0]),
        .i_d2u_src_avail  (src_avail[1]),
        .i_d2u_src_data   (src_data[1]),
        .o_d2u_src_read   (src_read[1]),
        .o_d2u_snk_data   (snk_data[1]),
        .o_d2u_snk_enable (snk_enable[1]),
        .i_d2u_snk_busy   (snk_busy[1]),
        .o_d2u_level      (level[1]),
        .o_err            (err),
        .i_err_clear      (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // Source side: offer a byte, complete the read handshake
    task automatic push(input int d, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        src_data[d]  = b;
        src_avail[d] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (src_read[d]) begin ok = 1'b1; break; end
        end
        src_avail[d] = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!src_read[d]) begin ok = 1'b1; break; end
        end
    endtask

    // Sink side: wait for enable, capture byte, acknowledge with busy
    task automatic accept(input int d, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 60; i++) begin
            if (snk_enable[d]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        b = snk_data[d];
        snk_busy[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!snk_enable[d]) begin ok = 1'b1; break; end
        end
        snk_busy[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; src_avail = 2'b00; snk_busy = 2'b00; err_clear = 1'b0;
        src_data[0] = 8'h00; src_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (src_read[d] !== 1'b0) begin n_err++; $display("FAIL reset_read[%0d]: got %b want 0", d, src_read[d]); end
            n_cmp++; if (snk_enable[d] !== 1'b0) begin n_err++; $display("FAIL reset_enable[%0d]: got %b want 0", d, snk_enable[d]); end
            n_cmp++; if (snk_data[d] !== 8'h00) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 00", d, snk_data[d]); end
            n_cmp++; if (level[d] !== 3'd0) begin n_err++; $display("FAIL reset_level[%0d]: got %0d want 0", d, level[d]); end
        end
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", err); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        src_data[0] = 8'hA5; src_avail[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (src_read[0] !== 1'b0) begin n_err++; $display("FAIL single_read_e1: got %b want 0", src_read[0]); end
        @(negedge clk);
        n_cmp++; if (src_read[0] !== 1'b1) begin n_err++; $display("FAIL single_read_e2: got %b want 1", src_read[0]); end
        n_cmp++; if (snk_enable[0] !== 1'b0) begin n_err++; $display("FAIL single_en_e2: got %b want 0", snk_enable[0]); end
        n_cmp++; if (level[0] !== 3'd1) begin n_err++; $display("FAIL single_level_e2: got %0d want 1", level[0]); end
        @(negedge clk);
        n_cmp++; if (snk_enable[0] !== 1'b1) begin n_err++; $display("FAIL single_en_e3: got %b want 1", snk_enable[0]); end
        n_cmp++; if (snk_data[0] !== 8'hA5) begin n_err++; $display("FAIL single_data_e3: got %h want a5", snk_data[0]); end
        n_cmp++; if (level[0] !== 3'd0) begin n_err++; $display("FAIL single_level_e3: got %0d want 0", level[0]); end
        src_avail[0] = 1'b0; snk_busy[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (snk_enable[0] !== 1'b1) begin n_err++; $display("FAIL single_en_sync: got %b want 1", snk_enable[0]); end
        @(negedge clk);
        n_cmp++; if (snk_enable[0] !== 1'b0) begin n_err++; $display("FAIL single_en_fall: got %b want 0", snk_enable[0]); end
        n_cmp++; if (src_read[0] !== 1'b0) begin n_err++; $display("FAIL single_read_fall: got %b want 0", src_read[0]); end
        snk_busy[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_burst;
        bit ok_a, ok_b;
        logic [7:0] got [6];
        snk_busy[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(i + 1), ok_a);
            n_cmp++; if (!ok_a) begin n_err++; $display("FAIL burst_push%0d: got timeout want handshake", i + 1); end
        end
        n_cmp++; if (level[0] !== 3'd4) begin n_err++; $display("FAIL burst_full_level: got %0d want 4", level[0]); end
        src_data[0] = 8'h05; src_avail[0] = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (src_read[0] !== 1'b0) begin n_err++; $display("FAIL burst_full_noread: got %b want 0", src_read[0]); end
        n_cmp++; if (level[0] !== 3'd4) begin n_err++; $display("FAIL burst_full_hold: got %0d want 4", level[0]); end
        ok_a = 1'b1; ok_b = 1'b1;
        fork
            begin
                bit o;
                push(0, 8'h05, o); ok_a &= o;
                push(0, 8'h06, o); ok_a &= o;
            end
            begin
                bit o;
                snk_busy[0] = 1'b0;
                for (int i = 0; i < 6; i++) begin accept(0, got[i], o); ok_b &= o; end
            end
        join
        n_cmp++; if (!(ok_a && ok_b)) begin n_err++; $display("FAIL burst_handshake: got src=%b snk=%b want 1/1", ok_a, ok_b); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (got[i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_order%0d: got %h want %h", i, got[i], 8'(i + 1)); end
        end
        n_cmp++; if (level[0] !== 3'd0) begin n_err++; $display("FAIL burst_drain: got %0d want 0", level[0]); end
    endtask

    task automatic test_timeout;
        int cnt;
        bit ok_a, ok_b;
        logic [7:0] b;
        src_data[0] = 8'h77; src_avail[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (src_read[0]) src_avail[0] = 1'b0;
            if (snk_enable[0]) break;
        end
        src_avail[0] = 1'b0;
        cnt = 0;
        while (snk_enable[0] && cnt < 30) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt !== 8) begin n_err++; $display("FAIL timeout_en_cycles: got %0d want 8", cnt); end
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL timeout_err: got %b want 01", err); end
        repeat (3) @(negedge clk);
        fork
            push(0, 8'h78, ok_a);
            accept(0, b, ok_b);
        join
        n_cmp++; if (b !== 8'h78 || !ok_b) begin n_err++; $display("FAIL timeout_next: got %h ok=%b want 78", b, ok_b); end
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL timeout_sticky: got %b want 01", err); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL timeout_clear: got %b want 00", err); end
    endtask

    task automatic test_push_pop;
        bit ok;
        logic [7:0] b;
        snk_busy[0] = 1'b1;
        repeat (3) @(negedge clk);
        push(0, 8'h41, ok);
        push(0, 8'h42, ok);
        n_cmp++; if (level[0] !== 3'd2) begin n_err++; $display("FAIL pp_setup_level: got %0d want 2", level[0]); end
        src_data[0] = 8'h43; src_avail[0] = 1'b1; snk_busy[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (src_read[0] !== 1'b1 || snk_enable[0] !== 1'b1) begin n_err++; $display("FAIL pp_both: got read=%b en=%b want 1/1", src_read[0], snk_enable[0]); end
        n_cmp++; if (level[0] !== 3'd2) begin n_err++; $display("FAIL pp_level: got %0d want 2", level[0]); end
        src_avail[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            accept(0, b, ok);
            n_cmp++; if (b !== 8'(8'h41 + i) || !ok) begin n_err++; $display("FAIL pp_order%0d: got %h ok=%b want %h", i, b, ok, 8'(8'h41 + i)); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok_a, ok_b;
        logic [7:0] b;
        snk_busy[0] = 1'b1;
        repeat (3) @(negedge clk);
        push(0, 8'h31, ok_a);
        push(0, 8'h32, ok_a);
        src_data[0] = 8'h33; src_avail[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (src_read[0]) break; end
        n_cmp++; if (src_read[0] !== 1'b1 || level[0] !== 3'd3) begin n_err++; $display("FAIL rmid_setup: got read=%b level=%0d want 1/3", src_read[0], level[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (src_read[0] !== 1'b0) begin n_err++; $display("FAIL rmid_read: got %b want 0", src_read[0]); end
        n_cmp++; if (snk_enable[0] !== 1'b0) begin n_err++; $display("FAIL rmid_enable: got %b want 0", snk_enable[0]); end
        n_cmp++; if (level[0] !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d want 0", level[0]); end
        n_cmp++; if (snk_data[0] !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", snk_data[0]); end
        src_avail[0] = 1'b0; snk_busy[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        fork
            push(0, 8'h3C, ok_a);
            accept(0, b, ok_b);
        join
        n_cmp++; if (b !== 8'h3C || !ok_a || !ok_b) begin n_err++; $display("FAIL rmid_after: got %h ok=%b%b want 3c", b, ok_a, ok_b); end
        n_cmp++; if (level[0] !== 3'd0) begin n_err++; $display("FAIL rmid_after_level: got %0d want 0", level[0]); end
    endtask

    task automatic test_both_dirs;
        bit o0, o1, o2, o3;
        logic [7:0] b0, b1;
        fork
            push(0, 8'h11, o0);
            push(1, 8'h22, o1);
            accept(0, b0, o2);
            accept(1, b1, o3);
        join
        n_cmp++; if (b0 !== 8'h11 || !o2) begin n_err++; $display("FAIL both_u2d: got %h want 11", b0); end
        n_cmp++; if (b1 !== 8'h22 || !o3) begin n_err++; $display("FAIL both_d2u: got %h want 22", b1); end
        push(1, 8'h99, o1);
        repeat (15) @(negedge clk);
        n_cmp++; if (err !== 2'b10) begin n_err++; $display("FAIL both_d2u_err: got %b want 10", err); end
        n_cmp++; if (snk_data[0] !== 8'h11) begin n_err++; $display("FAIL both_u2d_isolated: got %h want 11", snk_data[0]); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL both_clear: got %b want 00", err); end
    endtask

    task automatic test_err_collide;
        int cnt;
        src_data[0] = 8'h55; src_avail[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (src_read[0]) src_avail[0] = 1'b0;
            if (snk_enable[0]) break;
        end
        src_avail[0] = 1'b0;
        cnt = 0;
        while (snk_enable[0] && cnt < 30) begin
            cnt++;
            if (cnt == 8) err_clear = 1'b1;
            @(negedge clk);
        end
        err_clear = 1'b0;
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL collide_set_wins: got %b want 01", err); end
        @(negedge clk);
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL collide_sticky: got %b want 01", err); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL collide_clear: got %b want 00", err); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_timeout;
        test_push_pop;
        test_reset_mid;
        test_both_dirs;
        test_err_collide;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
